// File: rtl/pic_cmd_sequencer.sv
// Command-word sequencer for the 8259-compatible PIC: ICW1..ICW4 init walk, OCW1/2/3 decode, register reads.
// Optional cascade support (ICW3 state and storage, programmable SNGL) is enabled by defining PIC_CASCADE_EN.
module pic_cmd_sequencer #(
    parameter logic [7:0] RESET_IMR = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic [7:0] dout,
    output logic       ready,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] icw3,
    output logic       aeoi,
    output logic       sfnm,
    output logic       buf_mode,
    output logic       m_s,
    output logic       upm,
    output logic [7:0] imr,
    output logic       ocw2_stb,
    output logic       ocw2_r,
    output logic       ocw2_sl,
    output logic       ocw2_eoi,
    output logic [2:0] ocw2_lvl,
    output logic       rd_isr_sel,
    output logic       smm,
    output logic       poll_stb,
    output logic       seq_err
);
    typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  dout_q, dout_d, imr_q, imr_d;
    logic [2:0]  icw1_q, icw1_d;       // {ltim, sngl, ic4}
    logic [4:0]  vb_q, vb_d;
    logic [4:0]  icw4_q, icw4_d;       // {sfnm, buf_mode, m_s, aeoi, upm}
    logic [5:0]  ocw2_q, ocw2_d;       // {r, sl, eoi, lvl[2:0]}
    logic        rd_isr_sel_q, rd_isr_sel_d, smm_q, smm_d;
    logic        ocw2_stb_q, ocw2_stb_d, poll_stb_q, poll_stb_d, seq_err_q, seq_err_d;
    logic        icw1_hit;
`ifdef PIC_CASCADE_EN
    logic [7:0]  icw3_q, icw3_d;
`endif

    assign icw1_hit = wr_stb & ~a0 & din[4];

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        imr_d        = imr_q;
        icw1_d       = icw1_q;
        vb_d         = vb_q;
        icw4_d       = icw4_q;
        ocw2_d       = ocw2_q;
        rd_isr_sel_d = rd_isr_sel_q;
        smm_d        = smm_q;
        ocw2_stb_d   = 1'b0;
        poll_stb_d   = 1'b0;
        seq_err_d    = 1'b0;
`ifdef PIC_CASCADE_EN
        icw3_d       = icw3_q;
`endif
        // Read mux uses current register values, so a same-cycle write is not visible.
        if (rd_stb)
            dout_d = a0 ? imr_q : (rd_isr_sel_q ? isr_in : irr_in);

        if (icw1_hit) begin
`ifdef PIC_CASCADE_EN
            icw1_d = {din[3], din[1], din[0]};
`else
            icw1_d = {din[3], 1'b1, din[0]};
`endif
            imr_d        = 8'h00;
            smm_d        = 1'b0;
            rd_isr_sel_d = 1'b0;
            icw4_d       = 5'd0;
            state_d      = W_ICW2;
        end else if (wr_stb) begin
            case (state_q)
                UNINIT: seq_err_d = ~a0;
                W_ICW2: begin
                    if (a0) begin
                        vb_d = din[7:3];
`ifdef PIC_CASCADE_EN
                        if (!icw1_q[1]) state_d = W_ICW3; else
`endif
                        if (icw1_q[0]) state_d = W_ICW4;
                        else           state_d = READY;
                    end else
                        seq_err_d = 1'b1;
                end
`ifdef PIC_CASCADE_EN
                W_ICW3: begin
                    if (a0) begin
                        icw3_d  = din;
                        state_d = icw1_q[0] ? W_ICW4 : READY;
                    end else
                        seq_err_d = 1'b1;
                end
`endif
                W_ICW4: begin
                    if (a0) begin
                        icw4_d  = din[4:0];
                        state_d = READY;
                    end else
                        seq_err_d = 1'b1;
                end
                READY: begin
                    if (a0)
                        imr_d = din;
                    else if (!din[3]) begin
                        ocw2_d     = {din[7:5], din[2:0]};
                        ocw2_stb_d = 1'b1;
                    end else begin
                        if (din[1]) rd_isr_sel_d = din[0];
                        if (din[6]) smm_d = din[5];
                        poll_stb_d = din[2];
                    end
                end
                default: state_d = UNINIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= UNINIT;
            dout_q       <= 8'h00;
            imr_q        <= RESET_IMR;
            icw1_q       <= 3'd0;
            vb_q         <= 5'd0;
            icw4_q       <= 5'd0;
            ocw2_q       <= 6'd0;
            rd_isr_sel_q <= 1'b0;
            smm_q        <= 1'b0;
            ocw2_stb_q   <= 1'b0;
            poll_stb_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            imr_q        <= imr_d;
            icw1_q       <= icw1_d;
            vb_q         <= vb_d;
            icw4_q       <= icw4_d;
            ocw2_q       <= ocw2_d;
            rd_isr_sel_q <= rd_isr_sel_d;
            smm_q        <= smm_d;
            ocw2_stb_q   <= ocw2_stb_d;
            poll_stb_q   <= poll_stb_d;
            seq_err_q    <= seq_err_d;
        end
    end

`ifdef PIC_CASCADE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) icw3_q <= 8'h00;
        else       icw3_q <= icw3_d;
    end
    assign icw3 = icw3_q;
`else
    assign icw3 = 8'h00;
`endif

    assign ready       = (state_q == READY);
    assign dout        = dout_q;
    assign imr         = imr_q;
    assign {ltim, sngl, ic4} = icw1_q;
    assign vector_base = vb_q;
    assign {sfnm, buf_mode, m_s, aeoi, upm} = icw4_q;
    assign {ocw2_r, ocw2_sl, ocw2_eoi, ocw2_lvl} = ocw2_q;
    assign rd_isr_sel  = rd_isr_sel_q;
    assign smm         = smm_q;
    assign ocw2_stb    = ocw2_stb_q;
    assign poll_stb    = poll_stb_q;
    assign seq_err     = seq_err_q;
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Randomized self-checking bench for pic_cmd_sequencer against a queue-based command model.
module tb_pic_cmd_sequencer;
`ifdef PIC_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic wr_stb = 1'b0, rd_stb = 1'b0, a0 = 1'b0;
    logic [7:0] din = 8'h00, irr_in = 8'h00, isr_in = 8'h00;
    logic [7:0] dout, icw3, imr;
    logic ready, ltim, sngl, ic4, aeoi, sfnm, buf_mode, m_s, upm;
    logic [4:0] vector_base;
    logic ocw2_stb, ocw2_r, ocw2_sl, ocw2_eoi, rd_isr_sel, smm, poll_stb, seq_err;
    logic [2:0] ocw2_lvl;

    int n_chk = 0, n_fail = 0;

    pic_cmd_sequencer #(.RESET_IMR(8'hFF)) dut (
        .clk(clk), .reset(reset), .wr_stb(wr_stb), .rd_stb(rd_stb), .a0(a0), .din(din),
        .irr_in(irr_in), .isr_in(isr_in), .dout(dout), .ready(ready), .ltim(ltim), .sngl(sngl),
        .ic4(ic4), .vector_base(vector_base), .icw3(icw3), .aeoi(aeoi), .sfnm(sfnm),
        .buf_mode(buf_mode), .m_s(m_s), .upm(upm), .imr(imr), .ocw2_stb(ocw2_stb),
        .ocw2_r(ocw2_r), .ocw2_sl(ocw2_sl), .ocw2_eoi(ocw2_eoi), .ocw2_lvl(ocw2_lvl),
        .rd_isr_sel(rd_isr_sel), .smm(smm), .poll_stb(poll_stb), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Reference model: init progress is a queue of ICW numbers still owed.
    int   m_todo[$];
    bit   m_ready, m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_buf, m_ms, m_upm;
    bit   m_rdisr, m_smm, m_ocw2_stb, m_poll, m_err, m_r, m_sl, m_eoi;
    bit [2:0] m_lvl;
    bit [4:0] m_vb;
    bit [7:0] m_icw3, m_imr, m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_todo.delete();
        {m_ready, m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_buf, m_ms, m_upm} = '0;
        {m_rdisr, m_smm, m_ocw2_stb, m_poll, m_err, m_r, m_sl, m_eoi} = '0;
        m_lvl = 0; m_vb = 0; m_icw3 = 0; m_imr = 8'hFF; m_dout = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input bit a, input bit [7:0] d,
                              input bit [7:0] irr, input bit [7:0] isr);
        int k;
        m_ocw2_stb = 0; m_poll = 0; m_err = 0;
        if (r) m_dout = a ? m_imr : (m_rdisr ? isr : irr);
        if (!w) return;
        if (!a && d[4]) begin
            m_ltim = d[3]; m_ic4 = d[0]; m_sngl = CASC ? d[1] : 1'b1;
            m_imr = 0; m_smm = 0; m_rdisr = 0;
            {m_aeoi, m_sfnm, m_buf, m_ms, m_upm} = '0;
            m_ready = 0;
            m_todo.delete();
            m_todo.push_back(2);
            if (!m_sngl) m_todo.push_back(3);
            if (m_ic4) m_todo.push_back(4);
        end else if (!m_ready) begin
            if (!a) m_err = 1;
            else if (m_todo.size() != 0) begin
                k = m_todo.pop_front();
                if (k == 2) m_vb = d[7:3];
                else if (k == 3) m_icw3 = d;
                else begin
                    m_aeoi = d[1]; m_sfnm = d[4]; m_buf = d[3]; m_ms = d[2]; m_upm = d[0];
                end
                if (m_todo.size() == 0) m_ready = 1;
            end
        end else if (a) m_imr = d;
        else if (d[4:3] == 2'b00) begin
            m_r = d[7]; m_sl = d[6]; m_eoi = d[5]; m_lvl = d[2:0]; m_ocw2_stb = 1;
        end else begin
            if (d[1]) m_rdisr = d[0];
            if (d[6]) m_smm = d[5];
            m_poll = d[2];
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".ready"}, ready, m_ready);
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".imr"}, imr, m_imr);
        chk({tag, ".icw1"}, {ltim, sngl, ic4}, {m_ltim, m_sngl, m_ic4});
        chk({tag, ".vb"}, vector_base, m_vb);
        chk({tag, ".icw3"}, icw3, m_icw3);
        chk({tag, ".icw4"}, {aeoi, sfnm, buf_mode, m_s, upm}, {m_aeoi, m_sfnm, m_buf, m_ms, m_upm});
        chk({tag, ".ocw2"}, {ocw2_r, ocw2_sl, ocw2_eoi, ocw2_lvl}, {m_r, m_sl, m_eoi, m_lvl});
        chk({tag, ".ocw3"}, {rd_isr_sel, smm}, {m_rdisr, m_smm});
        chk({tag, ".pulses"}, {ocw2_stb, poll_stb, seq_err}, {m_ocw2_stb, m_poll, m_err});
    endtask

    // One clock with the given strobes; outputs checked 1 time unit after the edge.
    task automatic op(input string tag, input bit w, input bit r, input bit a, input bit [7:0] d,
                      input bit [7:0] irr = 8'h00, input bit [7:0] isr = 8'h00);
        wr_stb = w; rd_stb = r; a0 = a; din = d; irr_in = irr; isr_in = isr;
        @(posedge clk); #1;
        model_step(w, r, a, d, irr, isr);
        wr_stb = 0; rd_stb = 0;
        compare_all(tag);
    endtask

    task automatic wr(input string tag, input bit a, input bit [7:0] d);
        op(tag, 1'b1, 1'b0, a, d);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("rst");
        @(negedge clk); reset = 0;

        // Single, with ICW4.
        wr("icw1_13", 0, 8'h13);
        wr("icw2_48", 1, 8'h48);
        chk("plan1.vb", vector_base, 5'h09);
        chk("plan1.notready", ready, 1'b0);
        wr("icw4_03", 1, 8'h03);
        chk("plan1.aeoi_upm", {aeoi, upm, ready}, 3'b111);

        wr("ocw1_a5", 1, 8'hA5);
        chk("plan.imr", imr, 8'hA5);
        wr("ocw2_20", 0, 8'h20);
        chk("plan.ocw2", {ocw2_stb, ocw2_eoi, ocw2_lvl}, 5'b11000);
        op("idle", 0, 0, 0, 8'h00);
        chk("plan.ocw2_drop", ocw2_stb, 1'b0);

        wr("ocw3_0b", 0, 8'h0B);
        op("rd_isr", 0, 1, 0, 8'h00, 8'h81, 8'h10);
        chk("plan.dout_isr", dout, 8'h10);
        wr("ocw3_0a", 0, 8'h0A);
        op("rd_irr", 0, 1, 0, 8'h00, 8'h81, 8'h10);
        chk("plan.dout_irr", dout, 8'h81);

        // Simultaneous OCW1 write and imr read returns the old mask.
        op("wr_rd", 1, 1, 1, 8'h3C);
        chk("plan.old_imr", {dout, imr}, {8'hA5, 8'h3C});
        wr("ocw3_poll", 0, 8'h6C);
        chk("plan.poll_smm", {poll_stb, smm}, 2'b11);

        // Out-of-sequence write, then restart.
        wr("icw1_r", 0, 8'h13);
        wr("bad", 0, 8'h08);
        chk("plan.seq_err", {seq_err, ready}, 2'b10);
        wr("restart", 0, 8'h13);
        chk("plan.imr_clr", imr, 8'h00);
        wr("icw2_b", 1, 8'h48);

        // Cascaded sequence.
        wr("c_icw1", 0, 8'h11);
        wr("c_icw2", 1, 8'h20);
        wr("c_3rd", 1, 8'h04);
        if (CASC) chk("plan.casc_wait", ready, 1'b0);
        else      chk("plan.nocasc_3rd", {ready, m_s, icw3}, {2'b11, 8'h00});
        wr("c_4th", 1, 8'h01);
        if (CASC) chk("plan.casc_icw3", {ready, icw3, upm}, {1'b1, 8'h04, 1'b1});

        // Async reset mid-sequence (W_ICW3 or W_ICW4 depending on build).
        wr("r_icw1", 0, 8'h11);
        wr("r_icw2", 1, 8'h20);
        #2 reset = 1; #1;
        model_reset();
        compare_all("async_rst");
        chk("plan.rst_imr", {ready, imr}, {1'b0, 8'hFF});
        @(negedge clk); reset = 0;
        wr("post_rst", 1, 8'h55);
        chk("plan.post_rst", {ready, imr, vector_base}, {1'b0, 8'hFF, 5'h00});

        // Random traffic, ICW1 injected now and then to keep restarting.
        for (int i = 0; i < 600; i++) begin
            bit w, r, a;
            bit [7:0] d;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            a = $urandom_range(0, 1);
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin a = 0; d[4] = 1; end
            else if (!a && $urandom_range(0, 1) == 1) d[4] = 0;
            op("rnd", w, r, a, d, 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
